// File: rtl/bullet_pool.sv
`timescale 1ns/1ps
// bullet_pool: multi-slot player bullet manager.
// Launches one bullet per fire edge, with a cooldown between launches.
// Moves all live bullets up one pixel per rate tick.
// Resolves bullet hits against one square enemy and decrements its colour/health.
// Ports:
//   clk, resetn                    clock, async active-low reset
//   play, load_level               run enable, sync reinitialise
//   fire                           fire button (level)
//   playerX/Y, enemyX/Y            top-left pixel positions
//   enemy_width                    enemy side length (0 = no enemy)
//   bullet_valid, bullet_x/y       per-slot live flag and packed coordinates
//   move, enemy_hit                one-cycle event pulses
//   enemy_color, enemy_dead        enemy health, combinational dead flag
module bullet_pool #(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned RATE_DIV    = 500000,
  parameter int unsigned COOLDOWN    = 100000,
  parameter logic [2:0]  HEALTH_INIT = 3'b111
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     play,
  input  logic                     load_level,
  input  logic                     fire,
  input  logic [7:0]               playerX,
  input  logic [6:0]               playerY,
  input  logic [7:0]               enemyX,
  input  logic [6:0]               enemyY,
  input  logic [2:0]               enemy_width,
  output logic [NUM_BULLETS-1:0]   bullet_valid,
  output logic [8*NUM_BULLETS-1:0] bullet_x,
  output logic [7*NUM_BULLETS-1:0] bullet_y,
  output logic                     move,
  output logic                     enemy_hit,
  output logic [2:0]               enemy_color,
  output logic                     enemy_dead
);

  localparam int unsigned CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int unsigned CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN);

  logic [NUM_BULLETS-1:0] valid_q, valid_d;
  logic [7:0]             x_q [NUM_BULLETS];
  logic [7:0]             x_d [NUM_BULLETS];
  logic [6:0]             y_q [NUM_BULLETS];
  logic [6:0]             y_d [NUM_BULLETS];
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CD_W-1:0]        cd_q, cd_d;
  logic                   fire_q;
  logic [2:0]             color_d;
  logic                   move_d, hit_d;

  logic [NUM_BULLETS-1:0] hit_vec, free_vec, launch_oh;
  logic                   tick, launch, any_hit;
  logic [8:0]             ex_hi;
  logic [7:0]             ey_hi;

  // Enemy box bounds, widened so the far edge never wraps
  assign ex_hi = {1'b0, enemyX} + {6'b0, enemy_width} - 9'd1;
  assign ey_hi = {1'b0, enemyY} + {5'b0, enemy_width} - 8'd1;

  // Per-slot collision against the registered bullet positions
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      hit_vec[i] = valid_q[i] && (enemy_width != 3'd0) &&
                   ({1'b0, x_q[i]} >= {1'b0, enemyX}) && ({1'b0, x_q[i]} <= ex_hi) &&
                   ({1'b0, y_q[i]} >= {1'b0, enemyY}) && ({1'b0, y_q[i]} <= ey_hi);
    end
  end

  // Lowest free slot as a one-hot mask (isolate the lowest set bit)
  assign free_vec  = ~valid_q;
  assign launch_oh = free_vec & (~free_vec + NUM_BULLETS'(1));

  assign any_hit = |hit_vec;
  assign tick    = play && (cnt_q == CNT_MAX);
  assign launch  = play && fire && !fire_q && (cd_q == '0) && (|free_vec);

  // Next-state: hit-clear > launch > tick move/retire per slot
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    cd_d    = cd_q;
    color_d = enemy_color;
    move_d  = 1'b0;
    hit_d   = 1'b0;
    if (play) begin
      cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
      move_d = tick && (|valid_q);
      if (cd_q != '0) cd_d = cd_q - CD_W'(1);
      if (launch)     cd_d = CD_LOAD;
      if (any_hit) begin
        hit_d = 1'b1;
        if (enemy_color != 3'd0) color_d = enemy_color - 3'd1;
      end
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        if (hit_vec[i]) begin
          valid_d[i] = 1'b0;
        end else if (launch && launch_oh[i]) begin
          valid_d[i] = 1'b1;
          x_d[i]     = playerX + 8'd1;
          y_d[i]     = playerY;
        end else if (tick && valid_q[i]) begin
          if (y_q[i] == 7'd0) valid_d[i] = 1'b0;
          else                y_d[i]     = y_q[i] - 7'd1;
        end
      end
    end
  end

  // State register; load_level mirrors reset synchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q     <= '0;
      cnt_q       <= '0;
      cd_q        <= '0;
      fire_q      <= 1'b0;
      move        <= 1'b0;
      enemy_hit   <= 1'b0;
      enemy_color <= HEALTH_INIT;
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (load_level) begin
      valid_q     <= '0;
      cnt_q       <= '0;
      cd_q        <= '0;
      fire_q      <= 1'b0;
      move        <= 1'b0;
      enemy_hit   <= 1'b0;
      enemy_color <= HEALTH_INIT;
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      cd_q        <= cd_d;
      fire_q      <= fire;
      move        <= move_d;
      enemy_hit   <= hit_d;
      enemy_color <= color_d;
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  // Pack slot coordinates onto the flat output buses
  for (genvar g = 0; g < int'(NUM_BULLETS); g++) begin : g_pack
    assign bullet_x[8*g +: 8] = x_q[g];
    assign bullet_y[7*g +: 7] = y_q[g];
  end

  assign bullet_valid = valid_q;
  assign enemy_dead   = (enemy_color == 3'd0);

endmodule

// File: tb/tb_bullet_pool.sv
`timescale 1ns/1ps
// Directed self-checking bench for bullet_pool (2 slots, RATE_DIV=4, COOLDOWN=3).
module tb_bullet_pool;

  logic        clk = 1'b0;
  logic        resetn, play, load_level, fire;
  logic [7:0]  playerX, enemyX;
  logic [6:0]  playerY, enemyY;
  logic [2:0]  enemy_width;
  logic [1:0]  bullet_valid;
  logic [15:0] bullet_x;
  logic [13:0] bullet_y;
  logic        move, enemy_hit, enemy_dead;
  logic [2:0]  enemy_color;

  int checks   = 0;
  int failures = 0;

  bullet_pool #(
    .NUM_BULLETS(2), .RATE_DIV(4), .COOLDOWN(3), .HEALTH_INIT(3'b111)
  ) dut (
    .clk(clk), .resetn(resetn), .play(play), .load_level(load_level), .fire(fire),
    .playerX(playerX), .playerY(playerY), .enemyX(enemyX), .enemyY(enemyY),
    .enemy_width(enemy_width), .bullet_valid(bullet_valid), .bullet_x(bullet_x),
    .bullet_y(bullet_y), .move(move), .enemy_hit(enemy_hit),
    .enemy_color(enemy_color), .enemy_dead(enemy_dead)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load();
    load_level = 1'b1;
    step();
    load_level = 1'b0;
  endtask

  // Slot0 parked at y=114, slot1 launched into the enemy and hit: colour 6
  task automatic hit_setup();
    enemyX = 8'd80; enemyY = 7'd110; enemy_width = 3'd3; playerY = 7'd115;
    do_load();
    fire = 1'b1; step();
    fire = 1'b0; run(3);
    playerY = 7'd111;
    fire = 1'b1; step();
    fire = 1'b0; step();
    chk("pre_valid", 32'(bullet_valid), 32'd1);
    chk("pre_hit",   32'(enemy_hit),    32'd1);
    chk("pre_color", 32'(enemy_color),  32'd6);
  endtask

  task automatic chk_cleared(input string pfx);
    chk({pfx, "_valid"}, 32'(bullet_valid),  32'd0);
    chk({pfx, "_color"}, 32'(enemy_color),   32'd7);
    chk({pfx, "_move"},  32'(move),          32'd0);
    chk({pfx, "_hit"},   32'(enemy_hit),     32'd0);
    chk({pfx, "_y0"},    32'(bullet_y[6:0]), 32'd0);
  endtask

  initial begin
    logic saw_hit;
    resetn = 1'b0; play = 1'b0; load_level = 1'b0; fire = 1'b0;
    playerX = 8'd80; playerY = 7'd115;
    enemyX = 8'd80; enemyY = 7'd110; enemy_width = 3'd0;
    run(2);
    chk("rst_valid", 32'(bullet_valid), 32'd0);
    chk("rst_color", 32'(enemy_color),  32'd7);
    chk("rst_move",  32'(move),         32'd0);
    chk("rst_hit",   32'(enemy_hit),    32'd0);
    chk("rst_dead",  32'(enemy_dead),   32'd0);
    resetn = 1'b1; play = 1'b1;

    // Single shot: launch, then one pixel up per 4-cycle tick
    do_load();
    fire = 1'b1; step();
    chk("s1_valid", 32'(bullet_valid),  32'd1);
    chk("s1_x",     32'(bullet_x[7:0]), 32'd81);
    chk("s1_y",     32'(bullet_y[6:0]), 32'd115);
    chk("s1_move0", 32'(move),          32'd0);
    fire = 1'b0; run(3);
    chk("s1_y_t1",  32'(bullet_y[6:0]), 32'd114);
    chk("s1_move1", 32'(move),          32'd1);
    step();
    chk("s1_move_off", 32'(move), 32'd0);
    run(3);
    chk("s1_move2", 32'(move),          32'd1);
    chk("s1_y_t2",  32'(bullet_y[6:0]), 32'd113);

    // Cooldown drop, launch into slot1, full-pool drop
    do_load();
    fire = 1'b1; step();
    fire = 1'b0; step();
    fire = 1'b1; step();
    chk("s2_cd_drop", 32'(bullet_valid), 32'd1);
    fire = 1'b0; step();
    fire = 1'b1; step();
    chk("s2_valid2", 32'(bullet_valid),   32'd3);
    chk("s2_x1",     32'(bullet_x[15:8]), 32'd81);
    chk("s2_y1",     32'(bullet_y[13:7]), 32'd115);
    chk("s2_y0",     32'(bullet_y[6:0]),  32'd114);
    fire = 1'b0; run(3);
    fire = 1'b1; step();
    chk("s2_full_valid", 32'(bullet_valid),   32'd3);
    chk("s2_full_y0",    32'(bullet_y[6:0]),  32'd113);
    chk("s2_full_y1",    32'(bullet_y[13:7]), 32'd114);
    fire = 1'b0;

    // Held fire launches once
    do_load();
    fire = 1'b1; run(20);
    chk("s3_hold", 32'(bullet_valid), 32'd1);
    fire = 1'b0;

    // Fire rising while paused does not launch on unpause
    do_load();
    play = 1'b0; fire = 1'b1; run(2);
    play = 1'b1; run(3);
    chk("s3_pause", 32'(bullet_valid), 32'd0);
    fire = 1'b0;

    // Bullet climbs into enemy box (80..82, 110..112)
    enemy_width = 3'd3;
    do_load();
    fire = 1'b1; step();
    fire = 1'b0; run(11);
    chk("s4_valid_pre", 32'(bullet_valid),  32'd1);
    chk("s4_y_pre",     32'(bullet_y[6:0]), 32'd112);
    chk("s4_hit_pre",   32'(enemy_hit),     32'd0);
    step();
    chk("s4_valid", 32'(bullet_valid), 32'd0);
    chk("s4_hit",   32'(enemy_hit),    32'd1);
    chk("s4_color", 32'(enemy_color),  32'd6);
    step();
    chk("s4_hit_off", 32'(enemy_hit),   32'd0);
    chk("s4_color2",  32'(enemy_color), 32'd6);

    // Two bullets striking together cost one health
    do_load();
    playerY = 7'd115; fire = 1'b1; step();
    fire = 1'b0; run(3);
    playerY = 7'd114; fire = 1'b1; step();
    fire = 1'b0;
    chk("s5_y1", 32'(bullet_y[13:7]), 32'd114);
    run(7);
    chk("s5_valid_pre", 32'(bullet_valid),  32'd3);
    chk("s5_y0_pre",    32'(bullet_y[6:0]), 32'd112);
    step();
    chk("s5_valid", 32'(bullet_valid), 32'd0);
    chk("s5_hit",   32'(enemy_hit),    32'd1);
    chk("s5_color", 32'(enemy_color),  32'd6);

    // Retire at the top edge
    enemyX = 8'd200; enemyY = 7'd50; playerY = 7'd1;
    do_load();
    fire = 1'b1; step();
    fire = 1'b0; run(6);
    chk("s6_valid_top", 32'(bullet_valid),  32'd1);
    chk("s6_y_top",     32'(bullet_y[6:0]), 32'd0);
    step();
    chk("s6_retired", 32'(bullet_valid), 32'd0);
    chk("s6_move",    32'(move),         32'd1);
    chk("s6_nohit",   32'(enemy_hit),    32'd0);
    chk("s6_color",   32'(enemy_color),  32'd7);

    // Eight point-blank hits: colour saturates at 0
    enemyX = 8'd80; enemyY = 7'd110; playerY = 7'd111;
    do_load();
    for (int k = 1; k <= 8; k++) begin
      fire = 1'b1; step();
      fire = 1'b0; step();
      chk("s7_hit",   32'(enemy_hit),    32'd1);
      chk("s7_clear", 32'(bullet_valid), 32'd0);
      chk("s7_color", 32'(enemy_color),  (k <= 7) ? 32'(7 - k) : 32'd0);
      chk("s7_dead",  32'(enemy_dead),   (k >= 7) ? 32'd1 : 32'd0);
      run(2);
    end

    // Async reset mid-flight
    hit_setup();
    #2 resetn = 1'b0;
    #1 chk_cleared("s8_arst");
    resetn = 1'b1;

    // Synchronous load mid-flight
    hit_setup();
    load_level = 1'b1; step();
    load_level = 1'b0;
    chk_cleared("s8_load");

    // Zero-width enemy is never hit
    enemyX = 8'd80; enemyY = 7'd110; enemy_width = 3'd0; playerY = 7'd115;
    do_load();
    fire = 1'b1; step();
    fire = 1'b0;
    saw_hit = 1'b0;
    repeat (24) begin
      step();
      if (enemy_hit) saw_hit = 1'b1;
    end
    chk("s9_nohit", 32'(saw_hit),       32'd0);
    chk("s9_y",     32'(bullet_y[6:0]), 32'd109);
    chk("s9_color", 32'(enemy_color),   32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
